// File: rtl/dff_delay_line.sv
// ----------------------------------------------------------------------------
// dff_delay_line
//   DEPTH-stage, WIDTH-bit delay line built from enable-gated flops. Each
//   stage carries a valid bit. A synchronous flush clears the line. One
//   selectable tap is exposed, and a registered occupancy count tracks how
//   many stages currently hold valid data.
//
//   Build option: define DFF_GATE_INVALID_EN to force q / tap_q to RESET_VAL
//   whenever the associated valid bit is 0. Only the outputs are gated; the
//   stage flops are unchanged. qb always complements the presented q.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   enable     in   1      advance the line by one stage
//   d          in   WIDTH  data into stage 0
//   d_valid    in   1      valid bit accompanying d
//   flush      in   1      synchronous clear (priority over enable)
//   tap_sel    in   TAP_W  stage index shown on tap_q / tap_valid
//   q          out  WIDTH  data of the last stage
//   qb         out  WIDTH  bitwise complement of q
//   q_valid    out  1      valid bit of the last stage
//   tap_q      out  WIDTH  data of stage tap_sel (RESET_VAL if out of range)
//   tap_valid  out  1      valid bit of stage tap_sel (0 if out of range)
//   occupancy  out  OCC_W  number of valid stages
// ----------------------------------------------------------------------------
module dff_delay_line #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int              TAP_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int              OCC_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic             flush,
  input  logic [TAP_W-1:0] tap_sel,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             q_valid,
  output logic [WIDTH-1:0] tap_q,
  output logic             tap_valid,
  output logic [OCC_W-1:0] occupancy
);

  logic [WIDTH-1:0] stage_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [OCC_W-1:0] occ_r;

  logic [WIDTH-1:0] tap_raw_s;
  logic             tap_vld_s;
  logic [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] tap_s;

  // Stage data, valid bits and occupancy: reset > flush > enable > hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= RESET_VAL;
      end
      valid_r <= {DEPTH{1'b0}};
      occ_r   <= {OCC_W{1'b0}};
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= RESET_VAL;
      end
      valid_r <= {DEPTH{1'b0}};
      occ_r   <= {OCC_W{1'b0}};
    end else if (enable) begin
      stage_r[0] <= d;
      valid_r[0] <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
        valid_r[i] <= valid_r[i-1];
      end
      // One entry in, the last-stage entry out; both use pre-edge values,
      // so the count stays equal to the popcount of valid_r.
      occ_r <= occ_r + OCC_W'(d_valid) - OCC_W'(valid_r[DEPTH-1]);
    end
  end

  // Tap mux: an index matching no stage leaves the out-of-range defaults.
  always_comb begin
    tap_raw_s = RESET_VAL;
    tap_vld_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tap_sel == TAP_W'(i)) begin
        tap_raw_s = stage_r[i];
        tap_vld_s = valid_r[i];
      end else begin
        // not this stage; keep the selection made so far
      end
    end
  end

`ifdef DFF_GATE_INVALID_EN
  assign q_s   = valid_r[DEPTH-1] ? stage_r[DEPTH-1] : RESET_VAL;
  assign tap_s = tap_vld_s ? tap_raw_s : RESET_VAL;
`else
  assign q_s   = stage_r[DEPTH-1];
  assign tap_s = tap_raw_s;
`endif

  assign q         = q_s;
  assign qb        = ~q_s;
  assign q_valid   = valid_r[DEPTH-1];
  assign tap_q     = tap_s;
  assign tap_valid = tap_vld_s;
  assign occupancy = occ_r;

endmodule

// File: tb/tb_dff_delay_line.sv
// ----------------------------------------------------------------------------
// tb_dff_delay_line
//   Directed bench. Instance a: WIDTH=8, DEPTH=4, RESET_VAL=8'h00.
//   Instance b: WIDTH=8, DEPTH=3, RESET_VAL=8'h5A (tap range, non-zero reset
//   value). Both share clock, reset and line controls.
// ----------------------------------------------------------------------------
module tb_dff_delay_line;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] d;
  logic       d_valid;
  logic       flush;
  logic [1:0] tap_sel;
  logic [1:0] tap_sel_b;

  logic [7:0] q_a, qb_a, tapq_a;
  logic       qv_a, tapv_a;
  logic [2:0] occ_a;

  logic [7:0] q_b, qb_b, tapq_b;
  logic       qv_b, tapv_b;
  logic [1:0] occ_b;

  int checks = 0;
  int errors = 0;

`ifdef DFF_GATE_INVALID_EN
  localparam logic [7:0] INV_Q  = 8'h00;
  localparam logic [7:0] INV_QB = 8'hFF;
`else
  localparam logic [7:0] INV_Q  = 8'hF0;
  localparam logic [7:0] INV_QB = 8'h0F;
`endif

  dff_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_a (
    .clk(clk), .reset(reset), .enable(enable), .d(d), .d_valid(d_valid),
    .flush(flush), .tap_sel(tap_sel), .q(q_a), .qb(qb_a), .q_valid(qv_a),
    .tap_q(tapq_a), .tap_valid(tapv_a), .occupancy(occ_a)
  );

  dff_delay_line #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) u_b (
    .clk(clk), .reset(reset), .enable(enable), .d(d), .d_valid(d_valid),
    .flush(flush), .tap_sel(tap_sel_b), .q(q_b), .qb(qb_b), .q_valid(qv_b),
    .tap_q(tapq_b), .tap_valid(tapv_b), .occupancy(occ_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; d = 8'h00; d_valid = 1'b0; flush = 1'b0;
    tap_sel = 2'd0; tap_sel_b = 2'd0;
    tick(); tick();
    chk("rst_q_a", q_a, 8'h00);
    chk("rst_qb_b", qb_b, 8'hA5);
    reset = 1'b0;

    // 1: async reset mid-cycle after loading one entry
    enable = 1'b1; d = 8'hA5; d_valid = 1'b1;
    tick();
    chk("pre_rst_occ", occ_a, 3'd1);
    enable = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("arst_q", q_a, 8'h00);
    chk("arst_qb", qb_a, 8'hFF);
    chk("arst_qv", qv_a, 1'b0);
    chk("arst_occ", occ_a, 3'd0);
    chk("arst_q_b", q_b, 8'h5A);
    chk("arst_qb_b", qb_b, 8'hA5);
    reset = 1'b0;

    // 2: latency of DEPTH enabled edges, occupancy ramp
    enable = 1'b1; d_valid = 1'b1;
    d = 8'hA5; tick(); chk("lat_occ1", occ_a, 3'd1); chk("lat_qv1", qv_a, 1'b0);
    d = 8'h3C; tick(); chk("lat_occ2", occ_a, 3'd2);
    d = 8'h5A; tick(); chk("lat_occ3", occ_a, 3'd3); chk("lat_q3", q_a, 8'h00);
    d = 8'hC3; tick(); chk("lat_q4", q_a, 8'hA5); chk("lat_qv4", qv_a, 1'b1);
    chk("lat_occ4", occ_a, 3'd4);
    d = 8'h01; tick(); chk("lat_q5", q_a, 8'h3C); chk("lat_occ5", occ_a, 3'd4);

    // 4: flush beats enable; 8'h77 is never captured
    flush = 1'b1; enable = 1'b1; d = 8'h77; d_valid = 1'b1;
    tick();
    chk("fl_q", q_a, 8'h00);
    chk("fl_qb", qb_a, 8'hFF);
    chk("fl_qv", qv_a, 1'b0);
    chk("fl_occ", occ_a, 3'd0);
    chk("fl_tapv0", tapv_a, 1'b0);
    flush = 1'b0; d = 8'h00; d_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_no77", q_a, 8'h00);
    end
    chk("fl_occ_end", occ_a, 3'd0);

    // 3: stall for three cycles mid-stream
    enable = 1'b1; d_valid = 1'b1;
    d = 8'hA5; tick();
    d = 8'h3C; tick(); chk("st_occ2", occ_a, 3'd2);
    enable = 1'b0; d = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_hold_occ", occ_a, 3'd2);
      chk("st_hold_qv", qv_a, 1'b0);
    end
    enable = 1'b1;
    d = 8'h5A; tick(); chk("st_occ3", occ_a, 3'd3); chk("st_qv3", qv_a, 1'b0);
    d = 8'hC3; tick(); chk("st_q4", q_a, 8'hA5); chk("st_occ4", occ_a, 3'd4);
    d = 8'h01; tick(); chk("st_q5", q_a, 8'h3C);
    chk("st_tap0", tapq_a, 8'h01);

    flush = 1'b1; tick(); flush = 1'b0;
    chk("fl2_occ", occ_a, 3'd0);

    // 5: tap selection and out-of-range tap on the DEPTH=3 build
    enable = 1'b1; d_valid = 1'b1;
    d = 8'h11; tick();
    d = 8'h22; tick();
    d = 8'h33; tick();
    d = 8'h44; tick();
    enable = 1'b0;
    tap_sel = 2'd0; #1; chk("tap0", tapq_a, 8'h44); chk("tapv0", tapv_a, 1'b1);
    tap_sel = 2'd3; #1; chk("tap3", tapq_a, 8'h11);
    tap_sel = 2'd1; #1; chk("tap1", tapq_a, 8'h33);
    chk("tap_q_end", q_a, 8'h11);
    tap_sel_b = 2'd3; #1; chk("tapb_oor_q", tapq_b, 8'h5A); chk("tapb_oor_v", tapv_b, 1'b0);
    tap_sel_b = 2'd2; #1; chk("tapb2_q", tapq_b, 8'h22); chk("tapb2_v", tapv_b, 1'b1);
    chk("b_q", q_b, 8'h22);
    chk("b_occ", occ_b, 2'd3);

    flush = 1'b1; tick(); flush = 1'b0;
    tap_sel = 2'd0;

    // 6: valid pattern 1,0,1,0 with constant data
    enable = 1'b1; d = 8'hF0;
    d_valid = 1'b1; tick(); chk("vm_occ1", occ_a, 3'd1);
    d_valid = 1'b0; tick(); chk("vm_occ2", occ_a, 3'd1);
    d_valid = 1'b1; tick(); chk("vm_occ3", occ_a, 3'd2);
    d_valid = 1'b0; tick(); chk("vm_occ4", occ_a, 3'd2);
    chk("vm_q4", q_a, 8'hF0); chk("vm_qv4", qv_a, 1'b1);
    d_valid = 1'b1; tick();
    chk("vm_occ5", occ_a, 3'd2); chk("vm_qv5", qv_a, 1'b0);
    chk("vm_q5", q_a, INV_Q); chk("vm_qb5", qb_a, INV_QB);
    d_valid = 1'b0; tick();
    chk("vm_occ6", occ_a, 3'd2); chk("vm_qv6", qv_a, 1'b1);
    chk("vm_q6", q_a, 8'hF0);
    chk("vm_tapv6", tapv_a, 1'b0); chk("vm_tapq6", tapq_a, INV_Q);
    enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
